// File: rtl/imem_dmem_arbiter.sv
// imem_dmem_arbiter
//   Shares one req/rdy/valid memory port between the instruction fetcher
//   (I side) and the load/store unit (D side). One transaction in flight at a
//   time, round-robin on simultaneous requests, per-transaction response
//   timeout that returns an error to the owning side.
//
// Ports
//   clk, rst                     clock (rising edge), synchronous active-high reset
//   i_req, i_addr                fetch request; address held until i_rdy
//   i_rdy                        fetch accepted (combinational, 1-cycle pulse)
//   i_valid, i_rdata, i_err      fetch response (registered); i_err marks timeout
//   d_req, d_addr, d_we, d_wdata data request; payload held until d_rdy
//   d_rdy                        data accepted (combinational, 1-cycle pulse)
//   d_valid, d_rdata, d_err      data response (registered); d_err marks timeout
//   mem_req, mem_addr, mem_we,
//   mem_wdata                    registered request to memory, held until mem_rdy
//   mem_rdy                      memory accepts when mem_req && mem_rdy
//   mem_valid, mem_rdata         memory response (loads and stores alike)

module imem_dmem_arbiter #(
    parameter int unsigned BITS    = 32,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 7
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            i_req,
    input  logic [BITS-1:0] i_addr,
    output logic            i_rdy,
    output logic            i_valid,
    output logic [BITS-1:0] i_rdata,
    output logic            i_err,

    input  logic            d_req,
    input  logic [BITS-1:0] d_addr,
    input  logic            d_we,
    input  logic [BITS-1:0] d_wdata,
    output logic            d_rdy,
    output logic            d_valid,
    output logic [BITS-1:0] d_rdata,
    output logic            d_err,

    output logic            mem_req,
    output logic [BITS-1:0] mem_addr,
    output logic            mem_we,
    output logic [BITS-1:0] mem_wdata,
    input  logic            mem_rdy,
    input  logic            mem_valid,
    input  logic [BITS-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } state_e;

    localparam logic SIDE_I = 1'b0;
    localparam logic SIDE_D = 1'b1;

    // Timeout fires on the last permitted WAIT cycle; TIMEOUT == 0 disables it.
    localparam logic             TO_EN   = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    state_e           state_q;
    logic             owner_q;
    logic             last_grant_q;
    logic [CNT_W-1:0] cnt_q;

    logic             mem_req_q;
    logic [BITS-1:0]  mem_addr_q;
    logic             mem_we_q;
    logic [BITS-1:0]  mem_wdata_q;

    logic             i_valid_q;
    logic             i_err_q;
    logic [BITS-1:0]  i_rdata_q;
    logic             d_valid_q;
    logic             d_err_q;
    logic [BITS-1:0]  d_rdata_q;

    logic             grant_i_d;
    logic             grant_d_d;
    logic             done_d;
    logic             tout_d;

    // Grant decision: only in IDLE; on a tie the side that did not win last.
    always_comb begin
        grant_i_d = 1'b0;
        grant_d_d = 1'b0;
        if (state_q == IDLE) begin
            if (i_req && d_req) begin
                if (last_grant_q == SIDE_D) begin
                    grant_i_d = 1'b1;
                end else begin
                    grant_d_d = 1'b1;
                end
            end else begin
                grant_i_d = i_req;
                grant_d_d = d_req;
            end
        end
    end

    // Completion / timeout detection for the transaction in flight.
    // A response in ISSUE only counts together with the accept.
    always_comb begin
        done_d = 1'b0;
        tout_d = 1'b0;
        case (state_q)
            ISSUE: begin
                done_d = mem_rdy && mem_valid;
            end
            WAIT: begin
                done_d = mem_valid;
                tout_d = TO_EN && !mem_valid && (cnt_q == TO_LAST);
            end
            default: begin
                done_d = 1'b0;
                tout_d = 1'b0;
            end
        endcase
    end

    // Transaction FSM with registered memory-side and response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= SIDE_I;
            last_grant_q <= SIDE_D;
            cnt_q        <= '0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= '0;
            i_valid_q    <= 1'b0;
            i_err_q      <= 1'b0;
            i_rdata_q    <= '0;
            d_valid_q    <= 1'b0;
            d_err_q      <= 1'b0;
            d_rdata_q    <= '0;
        end else begin
            i_valid_q <= 1'b0;
            i_err_q   <= 1'b0;
            d_valid_q <= 1'b0;
            d_err_q   <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (grant_d_d) begin
                        owner_q      <= SIDE_D;
                        last_grant_q <= SIDE_D;
                        mem_req_q    <= 1'b1;
                        mem_addr_q   <= d_addr;
                        mem_we_q     <= d_we;
                        mem_wdata_q  <= d_wdata;
                        state_q      <= ISSUE;
                    end else if (grant_i_d) begin
                        owner_q      <= SIDE_I;
                        last_grant_q <= SIDE_I;
                        mem_req_q    <= 1'b1;
                        mem_addr_q   <= i_addr;
                        mem_we_q     <= 1'b0;
                        mem_wdata_q  <= '0;
                        state_q      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_rdy) begin
                        mem_req_q <= 1'b0;
                        cnt_q     <= '0;
                        state_q   <= done_d ? IDLE : WAIT;
                    end
                end
                WAIT: begin
                    if (done_d) begin
                        state_q <= IDLE;
                    end else if (tout_d) begin
                        state_q <= DRAIN;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DRAIN: begin
                    // The late response is swallowed here.
                    if (mem_valid) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase

            // Response to the owner; a timeout returns zero data with err set.
            if (done_d || tout_d) begin
                if (owner_q == SIDE_D) begin
                    d_valid_q <= 1'b1;
                    d_err_q   <= tout_d;
                    d_rdata_q <= tout_d ? '0 : mem_rdata;
                end else begin
                    i_valid_q <= 1'b1;
                    i_err_q   <= tout_d;
                    i_rdata_q <= tout_d ? '0 : mem_rdata;
                end
            end
        end
    end

    assign i_rdy     = grant_i_d;
    assign d_rdy     = grant_d_d;

    assign i_valid   = i_valid_q;
    assign i_err     = i_err_q;
    assign i_rdata   = i_rdata_q;
    assign d_valid   = d_valid_q;
    assign d_err     = d_err_q;
    assign d_rdata   = d_rdata_q;

    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Self-checking bench for imem_dmem_arbiter: scenario tasks with inline
// timing checks plus a response scoreboard fed at grant time.
module tb_imem_dmem_arbiter;

    localparam int unsigned BITS = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            i_req = 1'b0;
    logic [BITS-1:0] i_addr = '0;
    logic            i_rdy, i_valid, i_err;
    logic [BITS-1:0] i_rdata;
    logic            d_req = 1'b0;
    logic [BITS-1:0] d_addr = '0;
    logic            d_we = 1'b0;
    logic [BITS-1:0] d_wdata = '0;
    logic            d_rdy, d_valid, d_err;
    logic [BITS-1:0] d_rdata;
    logic            mem_req, mem_we;
    logic [BITS-1:0] mem_addr, mem_wdata;
    logic            mem_rdy = 1'b0;
    logic            mem_valid = 1'b0;
    logic [BITS-1:0] mem_rdata = '0;

    always #5 clk = ~clk;

    imem_dmem_arbiter #(.BITS(BITS), .TIMEOUT(4), .CNT_W(7)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdy(i_rdy), .i_valid(i_valid),
        .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
        .d_rdy(d_rdy), .d_valid(d_valid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdy(mem_rdy), .mem_valid(mem_valid),
        .mem_rdata(mem_rdata)
    );

    typedef struct packed {
        logic            side;   // 0 = I, 1 = D
        logic            err;
        logic [BITS-1:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    exp_t got, want;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    function automatic logic [BITS-1:0] mem_model(input logic [BITS-1:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    function automatic exp_t mk(input logic side, input logic err, input logic [BITS-1:0] rd);
        exp_t e;
        e.side  = side;
        e.err   = err;
        e.rdata = rd;
        return e;
    endfunction

    // Response scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (i_valid === 1'b1 && d_valid === 1'b1) begin
                n_tests++;
                n_fail++;
                $display("FAIL both_valid: i_valid=%b d_valid=%b, required at most one", i_valid, d_valid);
            end
            if (i_valid === 1'b1 || d_valid === 1'b1) begin
                got.side  = (d_valid === 1'b1);
                got.err   = got.side ? d_err : i_err;
                got.rdata = got.side ? d_rdata : i_rdata;
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: side=%0d err=%b rdata=%h, required no response",
                             got.side, got.err, got.rdata);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        n_fail++;
                        $display("FAIL sb_resp: side=%0d err=%b rdata=%h, required side=%0d err=%b rdata=%h",
                                 got.side, got.err, got.rdata, want.side, want.err, want.rdata);
                    end
                end
            end
        end
    end

    task automatic quiet_inputs();
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_addr = '0; d_we = 1'b0; d_wdata = '0;
        mem_rdy = 1'b0; mem_valid = 1'b0; mem_rdata = '0;
    endtask

    task automatic apply_reset();
        cyc();
        quiet_inputs();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        cyc();
        quiet_inputs();
        rst = 1'b1;
        smp();
        cyc();
        smp();
        n_tests++;
        if ({i_rdy, i_valid, i_err, d_rdy, d_valid, d_err, mem_req, mem_we} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_ctrl: ctrl=%b, required 00000000",
                     {i_rdy, i_valid, i_err, d_rdy, d_valid, d_err, mem_req, mem_we});
        end
        n_tests++;
        if ({i_rdata, d_rdata, mem_addr, mem_wdata} !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_data: i_rdata=%h d_rdata=%h mem_addr=%h mem_wdata=%h, required all 0",
                     i_rdata, d_rdata, mem_addr, mem_wdata);
        end
        cyc();
        rst = 1'b0;
        smp();
        n_tests++;
        if (mem_req !== 1'b0 || i_rdy !== 1'b0 || d_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: mem_req=%b i_rdy=%b d_rdy=%b, required 0 0 0", mem_req, i_rdy, d_rdy);
        end
    endtask

    task automatic test_single_fetch();
        cyc();
        i_req = 1'b1; i_addr = 32'h100;
        smp();
        n_tests++;
        if (i_rdy !== 1'b1 || d_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_rdy: i_rdy=%b d_rdy=%b, required 1 0", i_rdy, d_rdy);
        end
        exp_q.push_back(mk(1'b0, 1'b0, 32'h0050_0093));
        cyc();
        i_req = 1'b0; mem_rdy = 1'b1;
        smp();
        n_tests++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_issue: mem_req=%b mem_addr=%h mem_we=%b, required 1 00000100 0",
                     mem_req, mem_addr, mem_we);
        end
        cyc();
        mem_rdy = 1'b0;
        smp();
        cyc();
        mem_valid = 1'b1; mem_rdata = 32'h0050_0093;
        smp();
        n_tests++;
        if (mem_req !== 1'b0 || i_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_wait: mem_req=%b i_valid=%b, required 0 0", mem_req, i_valid);
        end
        cyc();
        mem_valid = 1'b0; mem_rdata = '0;
        smp();
        n_tests++;
        if (i_valid !== 1'b1 || d_valid !== 1'b0 || d_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_valid_cyc4: i_valid=%b d_valid=%b d_rdy=%b, required 1 0 0",
                     i_valid, d_valid, d_rdy);
        end
        cyc();
        smp();
        n_tests++;
        if (i_valid !== 1'b0 || i_rdata !== 32'h0050_0093) begin
            n_fail++;
            $display("FAIL fetch_hold: i_valid=%b i_rdata=%h, required 0 00500093", i_valid, i_rdata);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] gseq = '0;
        int         ng = 0;
        logic       have = 1'b0;
        logic       last_side = 1'b0;
        cyc();
        i_req = 1'b1; i_addr = 32'h300;
        d_req = 1'b1; d_addr = 32'h200; d_we = 1'b1; d_wdata = 32'hDEAD_BEEF;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) cyc();
            if (ng >= 4) begin
                i_req = 1'b0; d_req = 1'b0;
            end
            // Single-cycle memory: accept and respond in the ISSUE cycle.
            mem_rdy   = mem_req;
            mem_valid = mem_req;
            mem_rdata = mem_model(mem_addr);
            smp();
            if (have) begin
                n_tests++;
                if (mem_req !== 1'b1 || mem_we !== last_side ||
                    mem_addr !== (last_side ? 32'h200 : 32'h300) ||
                    (last_side && mem_wdata !== 32'hDEAD_BEEF)) begin
                    n_fail++;
                    $display("FAIL rr_mem_side%0d: req=%b we=%b addr=%h wdata=%h, required 1 %b %h %h",
                             last_side, mem_req, mem_we, mem_addr, mem_wdata, last_side,
                             last_side ? 32'h200 : 32'h300, 32'hDEAD_BEEF);
                end
                have = 1'b0;
            end
            if (i_rdy === 1'b1 && d_rdy === 1'b1) begin
                n_tests++;
                n_fail++;
                $display("FAIL rr_double_grant: i_rdy=%b d_rdy=%b, required one", i_rdy, d_rdy);
            end else if (i_rdy === 1'b1 || d_rdy === 1'b1) begin
                if (ng < 4) gseq[ng] = d_rdy;
                ng++;
                have = 1'b1;
                last_side = d_rdy;
                exp_q.push_back(mk(d_rdy, 1'b0, mem_model(d_rdy ? 32'h200 : 32'h300)));
            end
        end
        n_tests++;
        if (ng != 4 || gseq !== 4'b1010) begin
            n_fail++;
            $display("FAIL rr_order: grants=%0d seq(bit0 first)=%b, required 4 1010", ng, gseq);
        end
        cyc();
        quiet_inputs();
    endtask

    task automatic test_issue_stall();
        cyc();
        d_req = 1'b1; d_addr = 32'h440; d_we = 1'b0; d_wdata = 32'h1111_1111;
        mem_rdy = 1'b0; mem_valid = 1'b0;
        smp();
        n_tests++;
        if (d_rdy !== 1'b1 || i_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_grant: d_rdy=%b i_rdy=%b, required 1 0", d_rdy, i_rdy);
        end
        exp_q.push_back(mk(1'b1, 1'b0, 32'h1234_5678));
        for (int c = 1; c <= 5; c++) begin
            cyc();
            d_req = 1'b0; i_req = 1'b1; i_addr = 32'h500; mem_rdy = 1'b0;
            smp();
            n_tests++;
            if (mem_req !== 1'b1 || mem_addr !== 32'h440 || mem_we !== 1'b0 ||
                {i_rdy, d_rdy, i_valid, d_valid} !== 4'b0000) begin
                n_fail++;
                $display("FAIL stall_cyc%0d: mem_req=%b mem_addr=%h mem_we=%b rdy/valid=%b, required 1 00000440 0 0000",
                         c, mem_req, mem_addr, mem_we, {i_rdy, d_rdy, i_valid, d_valid});
            end
        end
        cyc();
        mem_rdy = 1'b1;
        smp();
        cyc();
        mem_rdy = 1'b0; mem_valid = 1'b1; mem_rdata = 32'h1234_5678;
        smp();
        n_tests++;
        if (mem_req !== 1'b0 || d_valid !== 1'b0 || i_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_wait: mem_req=%b d_valid=%b i_rdy=%b, required 0 0 0", mem_req, d_valid, i_rdy);
        end
        cyc();
        mem_valid = 1'b0;
        smp();
        n_tests++;
        if (d_valid !== 1'b1 || d_err !== 1'b0 || i_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_done: d_valid=%b d_err=%b i_rdy=%b, required 1 0 1", d_valid, d_err, i_rdy);
        end
        exp_q.push_back(mk(1'b0, 1'b0, 32'h0000_0073));
        cyc();
        i_req = 1'b0; mem_rdy = 1'b1; mem_valid = 1'b1; mem_rdata = 32'h0000_0073;
        smp();
        n_tests++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h500) begin
            n_fail++;
            $display("FAIL stall_next_issue: mem_req=%b mem_addr=%h, required 1 00000500", mem_req, mem_addr);
        end
        cyc();
        quiet_inputs();
        smp();
        n_tests++;
        if (i_valid !== 1'b1 || d_rdata !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL stall_next_done: i_valid=%b d_rdata=%h, required 1 12345678", i_valid, d_rdata);
        end
    endtask

    task automatic test_timeout();
        cyc();
        d_req = 1'b1; d_addr = 32'h600; d_we = 1'b0;
        smp();
        n_tests++;
        if (d_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL to_grant: d_rdy=%b, required 1", d_rdy);
        end
        exp_q.push_back(mk(1'b1, 1'b1, 32'h0));
        cyc();
        d_req = 1'b0; mem_rdy = 1'b1;
        smp();
        for (int c = 2; c <= 5; c++) begin
            cyc();
            mem_rdy = 1'b0;
            if (c >= 3) begin
                i_req = 1'b1; i_addr = 32'h700;
            end
            smp();
            n_tests++;
            if (d_valid !== 1'b0 || i_rdy !== 1'b0 || mem_req !== 1'b0) begin
                n_fail++;
                $display("FAIL to_wait_cyc%0d: d_valid=%b i_rdy=%b mem_req=%b, required 0 0 0",
                         c, d_valid, i_rdy, mem_req);
            end
        end
        cyc();
        smp();
        n_tests++;
        if (d_valid !== 1'b1 || d_err !== 1'b1 || d_rdata !== 32'h0 || i_valid !== 1'b0 || i_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL to_error: d_valid=%b d_err=%b d_rdata=%h i_valid=%b i_rdy=%b, required 1 1 00000000 0 0",
                     d_valid, d_err, d_rdata, i_valid, i_rdy);
        end
        cyc();
        smp();
        n_tests++;
        if (d_valid !== 1'b0 || i_rdy !== 1'b0 || mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL to_drain: d_valid=%b i_rdy=%b mem_req=%b, required 0 0 0", d_valid, i_rdy, mem_req);
        end
        cyc();
        mem_valid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        smp();
        n_tests++;
        if (i_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL to_drain_late: i_rdy=%b, required 0", i_rdy);
        end
        cyc();
        mem_valid = 1'b0;
        smp();
        n_tests++;
        if (i_valid !== 1'b0 || d_valid !== 1'b0 || i_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL to_discard: i_valid=%b d_valid=%b i_rdy=%b, required 0 0 1", i_valid, d_valid, i_rdy);
        end
        exp_q.push_back(mk(1'b0, 1'b0, 32'h0000_0013));
        cyc();
        i_req = 1'b0; mem_rdy = 1'b1; mem_valid = 1'b1; mem_rdata = 32'h0000_0013;
        smp();
        cyc();
        quiet_inputs();
        smp();
        n_tests++;
        if (i_valid !== 1'b1 || i_err !== 1'b0) begin
            n_fail++;
            $display("FAIL to_recover: i_valid=%b i_err=%b, required 1 0", i_valid, i_err);
        end
    endtask

    task automatic test_reset_in_wait();
        cyc();
        i_req = 1'b1; i_addr = 32'h800;
        smp();
        n_tests++;
        if (i_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL rw_grant: i_rdy=%b, required 1", i_rdy);
        end
        cyc();
        i_req = 1'b0; mem_rdy = 1'b1;
        smp();
        cyc();
        mem_rdy = 1'b0;
        smp();
        cyc();
        rst = 1'b1; mem_valid = 1'b1; mem_rdata = 32'h0000_CAFE;
        smp();
        cyc();
        rst = 1'b0; mem_valid = 1'b0; mem_rdata = '0;
        smp();
        n_tests++;
        if ({i_rdy, i_valid, i_err, d_rdy, d_valid, d_err, mem_req, mem_we} !== 8'h00 ||
            {i_rdata, d_rdata, mem_addr, mem_wdata} !== 128'h0) begin
            n_fail++;
            $display("FAIL rw_outputs: ctrl=%b i_rdata=%h mem_addr=%h, required 00000000 00000000 00000000",
                     {i_rdy, i_valid, i_err, d_rdy, d_valid, d_err, mem_req, mem_we}, i_rdata, mem_addr);
        end
        cyc();
        smp();
        n_tests++;
        if (i_valid !== 1'b0 || mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL rw_no_valid: i_valid=%b mem_req=%b, required 0 0", i_valid, mem_req);
        end
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        apply_reset();
        test_round_robin();
        test_issue_stall();
        test_timeout();
        test_reset_in_wait();
        repeat (3) cyc();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: pending=%0d, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
